// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Memory stage of a simple in-order pipeline. It accepts one op at a time
//   from the execute stage and does one of three things:
//   - Pass-through op (neither load nor store): the ALU result is forwarded
//     to writeback one cycle later.
//   - Load: issues a read and waits for dmem_ack. The addressed byte or
//     halfword lane is extracted from dmem_rdata, then sign- or zero-extended
//     and written back.
//   - Store: issues a write with byte lanes replicated and byte enables set.
//     A store writes no register.
//   Every op ends with exactly one wb_valid pulse.
//
// Optional feature (macro MEM_ALIGN_CHECK_EN):
//   When defined, a misaligned half/word access raises a fault pulse on
//   wb_err and issues no memory request.
//   When undefined, wb_err does not exist and misaligned addresses are
//   rounded down to natural alignment before the access.
//
// Handshakes:
//   in_valid/in_ready: an op transfers on a rising edge where both are high.
//     in_ready is high exactly while the FSM is IDLE.
//   dmem_req/dmem_ack: dmem_req stays high, with addr/we/wdata/be held stable,
//     until a rising edge where dmem_ack is high. dmem_ack is ignored whenever
//     dmem_req is low. dmem_rdata is taken in the same cycle as dmem_ack.
//   wb_valid: a single-cycle pulse. wb_we, wb_rd_num, wb_data (and wb_err)
//     are meaningful only while wb_valid is high.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready op handshake from the execute stage
//   is_ld, is_str     op kind (is_ld wins if both are set)
//   size              00 byte, 01 half, 10/11 word
//   ld_unsigned       zero-extend a byte/half load
//   result            ALU result / memory byte address
//   st_data           store data
//   rd_num            destination register index
//   dmem_*            data memory request/response
//   wb_*              writeback result pulse
//   state_dbg         1 while the FSM is in WAIT_ACK (debug visibility)
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_ld,
  input  logic              is_str,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] result,
  input  logic [31:0]       st_data,
  input  logic [REG_W-1:0]  rd_num,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd_num,
  output logic [31:0]       wb_data,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              wb_err,
`endif
  output logic              state_dbg
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t state;

  // Fields of the op in flight, captured at accept time.
  logic             op_load_q;
  logic [1:0]       op_size_q;
  logic             op_unsigned_q;
  logic [REG_W-1:0] op_rd_q;

  // Incoming op decode.
  logic              in_mem;
  logic              in_store;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;

  // Load data after lane extraction and extension.
  logic [31:0] load_val;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign in_ready  = (state == IDLE);
  assign state_dbg = (state == WAIT_ACK);

  // is_ld takes precedence, so a store is only a store when is_ld is low.
  assign in_mem   = is_ld | is_str;
  assign in_store = is_str & ~is_ld;

`ifdef MEM_ALIGN_CHECK_EN
  logic in_misaligned;
  assign in_misaligned = ((size == 2'b01) && result[0]) ||
                         (size[1] && (result[1:0] != 2'b00));
`endif

  // Natural alignment of the request address. With the alignment check
  // enabled, misaligned ops never reach memory, so rounding down is harmless
  // there too.
  always_comb begin
    req_addr = result;
    if (size == 2'b01) begin
      req_addr[0] = 1'b0;
    end else if (size[1]) begin
      req_addr[1:0] = 2'b00;
    end
  end

  // Store encoding: the data is replicated across every lane of the access
  // size, so memory only has to honour the byte enables.
  always_comb begin
    req_wdata = st_data;
    req_be    = 4'b1111;
    case (size)
      2'b00: begin
        req_wdata = {4{st_data[7:0]}};
        req_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        req_wdata = {2{st_data[15:0]}};
        req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        req_wdata = st_data;
        req_be    = 4'b1111;
      end
    endcase
  end

  // Lane selection uses the held request address. It is already aligned, so
  // for a halfword only bit 1 matters.
  always_comb begin
    byte_lane = dmem_rdata[7:0];
    case (dmem_addr[1:0])
      2'b00:   byte_lane = dmem_rdata[7:0];
      2'b01:   byte_lane = dmem_rdata[15:8];
      2'b10:   byte_lane = dmem_rdata[23:16];
      default: byte_lane = dmem_rdata[31:24];
    endcase
    half_lane = dmem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  end

  always_comb begin
    load_val = dmem_rdata;
    case (op_size_q)
      2'b00: begin
        load_val = op_unsigned_q ? {24'h000000, byte_lane}
                                 : {{24{byte_lane[7]}}, byte_lane};
      end
      2'b01: begin
        load_val = op_unsigned_q ? {16'h0000, half_lane}
                                 : {{16{half_lane[15]}}, half_lane};
      end
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= 4'b0000;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd_num     <= '0;
      wb_data       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      wb_err        <= 1'b0;
`endif
      op_load_q     <= 1'b0;
      op_size_q     <= 2'b00;
      op_unsigned_q <= 1'b0;
      op_rd_q       <= '0;
    end else begin
      // The writeback pulse lasts one cycle unless a completion re-arms it.
      wb_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_mem) begin
              // Pass-through: forward the ALU result, zero-extended to 32 bits.
              wb_valid  <= 1'b1;
              wb_we     <= 1'b1;
              wb_rd_num <= rd_num;
              wb_data   <= 32'(result);
`ifdef MEM_ALIGN_CHECK_EN
              wb_err    <= 1'b0;
`endif
            end
`ifdef MEM_ALIGN_CHECK_EN
            else if (in_misaligned) begin
              // Fault: report it without touching memory.
              wb_valid  <= 1'b1;
              wb_we     <= 1'b0;
              wb_rd_num <= rd_num;
              wb_data   <= 32'h0000_0000;
              wb_err    <= 1'b1;
            end
`endif
            else begin
              state         <= WAIT_ACK;
              dmem_req      <= 1'b1;
              dmem_we       <= in_store;
              dmem_addr     <= req_addr;
              dmem_wdata    <= in_store ? req_wdata : 32'h0000_0000;
              dmem_be       <= in_store ? req_be : 4'b1111;
              op_load_q     <= ~in_store;
              op_size_q     <= size;
              op_unsigned_q <= ld_unsigned;
              op_rd_q       <= rd_num;
            end
          end
        end

        WAIT_ACK: begin
          // dmem_req is high throughout this state, so the ack is sampled
          // only here.
          if (dmem_ack) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            wb_valid  <= 1'b1;
            wb_we     <= op_load_q;
            wb_rd_num <= op_rd_q;
            wb_data   <= op_load_q ? load_val : 32'h0000_0000;
`ifdef MEM_ALIGN_CHECK_EN
            wb_err    <= 1'b0;
`endif
          end
        end

        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed corner cases followed by randomized ops. Each result is checked
// against a reference model written from the access rules: address rounding,
// byte-lane arithmetic, and sign extension done with integer math.
// Build with +define+MEM_ALIGN_CHECK_EN to exercise the alignment-fault
// variant of the unit.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              in_valid;
  logic              in_ready;
  logic              is_ld;
  logic              is_str;
  logic [1:0]        size;
  logic              ld_unsigned;
  logic [ADDR_W-1:0] result;
  logic [31:0]       st_data;
  logic [REG_W-1:0]  rd_num;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;
  logic              wb_valid;
  logic              wb_we;
  logic [REG_W-1:0]  wb_rd_num;
  logic [31:0]       wb_data;
  logic              state_dbg;
`ifdef MEM_ALIGN_CHECK_EN
  logic              wb_err;
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  mem_access_unit #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_ld       (is_ld),
    .is_str      (is_str),
    .size        (size),
    .ld_unsigned (ld_unsigned),
    .result      (result),
    .st_data     (st_data),
    .rd_num      (rd_num),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_rd_num   (wb_rd_num),
    .wb_data     (wb_data),
`ifdef MEM_ALIGN_CHECK_EN
    .wb_err      (wb_err),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd1) return a - (a % 2);
    if (sz >= 2'd2) return a - (a % 4);
    return a;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
    int lane;
    lane = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << lane);
    if (sz == 2'd1) return 4'(3 << (2 * (lane / 2)));
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a,
                                             input logic [1:0] sz, input bit uns);
    logic [31:0] v;
    int lane;
    lane = int'(a % 4);
    if (sz == 2'd0) begin
      v = (rdata >> (8 * lane)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rdata >> (16 * (lane / 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Starts and ends just after a falling edge; outputs are sampled there.
  task automatic do_op(input string tag, input bit ld_i, input bit st_i, input logic [1:0] sz,
                       input bit uns, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input int waits, input logic [31:0] rdata);
    bit mem, load, mis;
    logic [31:0] ea;
    mem  = ld_i | st_i;
    load = ld_i;
    mis  = (sz == 2'd1 && (res % 2) != 0) || (sz >= 2'd2 && (res % 4) != 0);
    ea   = model_addr(res, sz);

    check({tag, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; is_ld = ld_i; is_str = st_i; size = sz; ld_unsigned = uns;
    result = res; st_data = sd; rd_num = rd;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; is_ld = $urandom_range(0, 1); is_str = $urandom_range(0, 1);
    result = $urandom; st_data = $urandom; rd_num = 5'($urandom);

    if (!mem) begin
      exp_q.push_back(res);
      check({tag, ".pt_wb_valid"}, wb_valid, 1);
      check({tag, ".pt_wb_we"}, wb_we, 1);
      check({tag, ".pt_wb_data"}, wb_data, exp_q.pop_front());
      check({tag, ".pt_wb_rd"}, wb_rd_num, rd);
      check({tag, ".pt_req"}, dmem_req, 0);
      check({tag, ".pt_ready"}, in_ready, 1);
    end else if (mis && CHECK_EN) begin
      check({tag, ".mis_wb_valid"}, wb_valid, 1);
      check({tag, ".mis_wb_we"}, wb_we, 0);
`ifdef MEM_ALIGN_CHECK_EN
      check({tag, ".mis_wb_err"}, wb_err, 1);
`endif
      check({tag, ".mis_req"}, dmem_req, 0);
      check({tag, ".mis_ready"}, in_ready, 1);
    end else begin
      exp_q.push_back(load ? model_load(rdata, ea, sz, uns) : 32'd0);
      for (int i = 0; i <= waits; i++) begin
        check({tag, ".req"}, dmem_req, 1);
        check({tag, ".ready_low"}, in_ready, 0);
        check({tag, ".wb_quiet"}, wb_valid, 0);
        check({tag, ".addr"}, dmem_addr, ea);
        check({tag, ".we"}, dmem_we, !load);
        check({tag, ".be"}, dmem_be, load ? 4'd15 : model_be(ea, sz));
        if (!load) check({tag, ".wdata"}, dmem_wdata, model_wdata(sd, sz));
        dmem_ack   = (i == waits);
        dmem_rdata = (i == waits) ? rdata : $urandom;
        @(posedge clk); @(negedge clk);
      end
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      check({tag, ".wb_valid"}, wb_valid, 1);
      check({tag, ".wb_we"}, wb_we, load);
      check({tag, ".wb_data"}, wb_data, exp_q.pop_front());
      check({tag, ".wb_rd"}, wb_rd_num, rd);
`ifdef MEM_ALIGN_CHECK_EN
      check({tag, ".wb_err"}, wb_err, 0);
`endif
      check({tag, ".req_drop"}, dmem_req, 0);
    end
    @(posedge clk); @(negedge clk);
    check({tag, ".wb_pulse_end"}, wb_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; in_valid = 1'b0; is_ld = 1'b0; is_str = 1'b0; size = 2'd0;
    ld_unsigned = 1'b0; result = '0; st_data = '0; rd_num = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    #3 rst_n = 1'b0;
    #1;
    check("rst.ready", in_ready, 1);
    check("rst.state", state_dbg, 0);
    check("rst.req", dmem_req, 0);
    check("rst.we", dmem_we, 0);
    check("rst.be", dmem_be, 0);
    check("rst.addr", dmem_addr, 0);
    check("rst.wdata", dmem_wdata, 0);
    check("rst.wb_valid", wb_valid, 0);
    check("rst.wb_data", wb_data, 0);
    check("rst.wb_rd", wb_rd_num, 0);
`ifdef MEM_ALIGN_CHECK_EN
    check("rst.wb_err", wb_err, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op("passthru", 0, 0, 2'd0, 0, 32'h1234, 32'h0, 5'd3, 0, 32'h0);
    do_op("ld_byte_signed", 1, 0, 2'd0, 0, 32'h102, 32'h0, 5'd7, 3, 32'h0080_0000);
    do_op("st_half", 0, 1, 2'd1, 0, 32'h2, 32'hABCD_1234, 5'd1, 1, 32'h0);
    do_op("ld_immediate_ack", 1, 0, 2'd2, 0, 32'h40, 32'h0, 5'd9, 0, 32'hDEAD_BEEF);
    do_op("ld_half_unsigned", 1, 0, 2'd1, 1, 32'h12, 32'h0, 5'd4, 2, 32'h8001_7FFF);
    do_op("both_high_is_load", 1, 1, 2'd0, 1, 32'h3, 32'h55, 5'd6, 1, 32'hC3B2_A190);
    do_op("st_byte_lane3", 0, 1, 2'd0, 0, 32'h7, 32'h0000_00A5, 5'd2, 0, 32'h0);
    do_op("word_misaligned", 1, 0, 2'd2, 0, 32'h6, 32'h0, 5'd5, 1, 32'h1111_2222);
    do_op("half_misaligned_st", 0, 1, 2'd1, 0, 32'h5, 32'h0000_BEEF, 5'd8, 0, 32'h0);

    // Reset in the middle of a pending access; a late ack must be ignored.
    in_valid = 1'b1; is_ld = 1'b1; is_str = 1'b0; size = 2'd2; result = 32'h80; rd_num = 5'd12;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("midrst.req_before", dmem_req, 1);
    rst_n = 1'b0;
    #1;
    check("midrst.req_now", dmem_req, 0);
    check("midrst.state", state_dbg, 0);
    check("midrst.addr", dmem_addr, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    check("midrst.no_wb", wb_valid, 0);
    check("midrst.no_req", dmem_req, 0);
    check("midrst.ready", in_ready, 1);
    @(posedge clk); @(negedge clk);
    check("midrst.still_no_wb", wb_valid, 0);

    // Randomized ops.
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      do_op("rand", kind == 1 || kind == 3, kind == 2 || kind == 3,
            2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), $urandom, $urandom,
            5'($urandom), $urandom_range(0, 3), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
